// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
// Frame-rate ball motion controller for the Pong display path. It owns the
// ball position and direction and advances the ball once per frameTick. It
// handles top/bottom wall bounces, paddle hits and misses, and the
// serve -> launch -> score -> recentre sequence.
//
// Ports:
//   clock       system/pixel clock
//   reset       synchronous, active-high reset
//   frameTick   one-cycle pulse per frame (start of vertical blank)
//   serve       serve request level, only looked at while idle
//   padLeftY    left paddle top y (sampled on frameTick cycles only)
//   padRightY   right paddle top y (sampled on frameTick cycles only)
//   ballX       ball top-left x (registered)
//   ballY       ball top-left y (registered)
//   ballColour  rgb selector for the ball drawer (registered)
//   scoreLeft   one-cycle pulse, left player won the point
//   scoreRight  one-cycle pulse, right player won the point
//   inPlay      high while the ball is moving
module pong_ball_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 5,
  parameter int PAD_W       = 5,
  parameter int PAD_H       = 40,
  parameter int PAD_L_X     = 20,
  parameter int PAD_R_X     = 615,
  parameter int SPEED       = 2,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frameTick,
  input  logic       serve,
  input  logic [9:0] padLeftY,
  input  logic [9:0] padRightY,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [2:0] ballColour,
  output logic       scoreLeft,
  output logic       scoreRight,
  output logic       inPlay
);

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY + 1) : 1;

  localparam logic [9:0]  CENTRE_X  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CENTRE_Y  = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  BOTTOM_Y  = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  RIGHT_X   = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  LEFT_HITX = 10'(PAD_L_X + PAD_W);
  localparam logic [9:0]  RIGHT_HITX = 10'(PAD_R_X - BALL_SIZE);
  localparam logic [9:0]  STEP10    = 10'(SPEED);

  localparam logic [10:0] SPEED11   = 11'(SPEED);
  localparam logic [10:0] SIZE11    = 11'(BALL_SIZE);
  localparam logic [10:0] PADH11    = 11'(PAD_H);
  localparam logic [10:0] SCRW11    = 11'(SCREEN_W);
  localparam logic [10:0] SCRH11    = 11'(SCREEN_H);
  localparam logic [10:0] LFACE11   = 11'(PAD_L_X + PAD_W);
  localparam logic [10:0] RFACE11   = 11'(PAD_R_X);
  localparam logic [CW-1:0] LAST_CNT = CW'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_WAIT,
    MOVE,
    SCORED
  } stateT;

  stateT         state, stateNext;
  logic          dirX, dirXNext;
  logic          dirY, dirYNext;
  logic [CW-1:0] serveCnt, serveCntNext;
  logic [9:0]    xNext, yNext;
  logic          scoreLeftNext, scoreRightNext;
  logic [2:0]    colourNext;

  // 11-bit views of the positions so that no comparison sum can wrap.
  logic [10:0] x11, y11, padL11, padR11, lead11;
  logic        overlapLeft, overlapRight;

  assign x11    = {1'b0, ballX};
  assign y11    = {1'b0, ballY};
  assign padL11 = {1'b0, padLeftY};
  assign padR11 = {1'b0, padRightY};
  assign lead11 = x11 + SIZE11;

  // Paddle overlap is judged on the ball position before this frame's step.
  assign overlapLeft  = (y11 + SIZE11 > padL11) && (y11 < padL11 + PADH11);
  assign overlapRight = (y11 + SIZE11 > padR11) && (y11 < padR11 + PADH11);

  // State register plus all registered outputs; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ballX      <= CENTRE_X;
      ballY      <= CENTRE_Y;
      dirX       <= 1'b1;
      dirY       <= 1'b1;
      serveCnt   <= '0;
      scoreLeft  <= 1'b0;
      scoreRight <= 1'b0;
      inPlay     <= 1'b0;
      ballColour <= 3'b010;
    end else begin
      state      <= stateNext;
      ballX      <= xNext;
      ballY      <= yNext;
      dirX       <= dirXNext;
      dirY       <= dirYNext;
      serveCnt   <= serveCntNext;
      scoreLeft  <= scoreLeftNext;
      scoreRight <= scoreRightNext;
      inPlay     <= (stateNext == MOVE);
      ballColour <= colourNext;
    end
  end

  // Next-state and motion logic. dirX=1 means moving right, dirY=1 means
  // moving down. Colour is derived from the state being entered so the
  // registered colour always matches the registered state.
  always_comb begin
    stateNext      = state;
    xNext          = ballX;
    yNext          = ballY;
    dirXNext       = dirX;
    dirYNext       = dirY;
    serveCntNext   = serveCnt;
    scoreLeftNext  = 1'b0;
    scoreRightNext = 1'b0;

    case (state)
      IDLE: begin
        if (serve) begin
          stateNext    = SERVE_WAIT;
          serveCntNext = '0;
        end
      end

      SERVE_WAIT: begin
        if (frameTick) begin
          if (serveCnt == LAST_CNT) begin
            stateNext = MOVE;
          end else begin
            serveCntNext = serveCnt + 1'b1;
          end
        end
      end

      MOVE: begin
        if (frameTick) begin
          if (dirY) begin
            if (y11 + SPEED11 + SIZE11 > SCRH11) begin
              yNext    = BOTTOM_Y;
              dirYNext = 1'b0;
            end else begin
              yNext = ballY + STEP10;
            end
          end else begin
            if (y11 < SPEED11) begin
              yNext    = '0;
              dirYNext = 1'b1;
            end else begin
              yNext = ballY - STEP10;
            end
          end

          // A hit needs the ball to cross the paddle face during this step;
          // a ball already past the face falls through to the edge test.
          if (!dirX) begin
            if ((x11 >= LFACE11) && (x11 < LFACE11 + SPEED11) && overlapLeft) begin
              xNext    = LEFT_HITX;
              dirXNext = 1'b1;
            end else if (x11 < SPEED11) begin
              xNext          = '0;
              stateNext      = SCORED;
              scoreRightNext = 1'b1;
              dirXNext       = 1'b0;
            end else begin
              xNext = ballX - STEP10;
            end
          end else begin
            if ((lead11 <= RFACE11) && (lead11 + SPEED11 > RFACE11) && overlapRight) begin
              xNext    = RIGHT_HITX;
              dirXNext = 1'b0;
            end else if (lead11 + SPEED11 > SCRW11) begin
              xNext         = RIGHT_X;
              stateNext     = SCORED;
              scoreLeftNext = 1'b1;
              dirXNext      = 1'b1;
            end else begin
              xNext = ballX + STEP10;
            end
          end
        end
      end

      SCORED: begin
        // Serve direction (dirX) was already pointed at the loser on the miss.
        if (frameTick) begin
          xNext     = CENTRE_X;
          yNext     = CENTRE_Y;
          dirYNext  = ~dirY;
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Ball colour for the state about to be entered.
  always_comb begin
    colourNext = 3'b010;
    case (stateNext)
      IDLE:       colourNext = 3'b010;
      SERVE_WAIT: colourNext = 3'b110;
      MOVE:       colourNext = 3'b111;
      SCORED:     colourNext = 3'b100;
      default:    colourNext = 3'b010;
    endcase
  end

endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
Frame-rate ball motion controller for the Pong display path. It owns the ball's position and direction and advances it once per video frame. It handles wall bounces, paddle hits and misses, and runs the serve/score sequence. Its ballX/ballY/ballColour outputs drive the ball's filled-box drawer, and it reads paddle Y positions from the paddle logic.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 5, ball edge length in pixels (square)
PAD_W, 5, paddle width
PAD_H, 40, paddle height
PAD_L_X, 20, left paddle x (left edge)
PAD_R_X, 615, right paddle x (left edge)
SPEED, 2, pixels moved per frame on each axis; must be >=1
SERVE_DELAY, 60, frames between serve request and launch; must be >=1

Ports:
clock  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
frameTick  in  1  one-cycle pulse per frame, at start of vertical blank
serve  in  1  serve request, level, sampled every cycle in IDLE
padLeftY  in  10  left paddle top y
padRightY  in  10  right paddle top y
ballX  out  10  ball top-left x
ballY  out  10  ball top-left y
ballColour  out  3  rgb selector for the ball drawer
scoreLeft  out  1  one-cycle pulse: left player won the point
scoreRight  out  1  one-cycle pulse: right player won the point
inPlay  out  1  high while in MOVE

Behaviour:
- Reset is synchronous and has priority over every other event, including mid-rally.
- Reset values:
  - ballX = (SCREEN_W-BALL_SIZE)/2 (317), ballY = (SCREEN_H-BALL_SIZE)/2 (237).
  - dirX = right, dirY = down, state = IDLE, serve counter = 0.
  - scoreLeft = scoreRight = 0, inPlay = 0, ballColour = 3'b010.
- All arithmetic is done in 11 bits unsigned, so no sum can wrap. Outputs are registered.
- States:
  - IDLE: ball centred, ballColour = 3'b010 (green). serve=1 -> SERVE_WAIT with counter cleared. A frameTick in the same cycle is ignored.
  - SERVE_WAIT: ballColour = 3'b110 (yellow). Each frameTick increments the counter. The tick on which counter == SERVE_DELAY-1 moves to MOVE without moving the ball. serve is ignored.
  - MOVE: ballColour = 3'b111 (white), inPlay = 1. Each frameTick applies one step; positions change on the clock edge that samples frameTick high (latency 1 cycle).
  - SCORED: ballColour = 3'b100 (red). The ball holds its clamped position. The next frameTick recentres the ball, toggles dirY and goes to IDLE.
- Vertical step (MOVE only):
  - Moving down and ballY+SPEED+BALL_SIZE > SCREEN_H: ballY = SCREEN_H-BALL_SIZE, dirY = up.
  - Moving up and ballY < SPEED: ballY = 0, dirY = down.
  - Otherwise ballY moves by ±SPEED.
- Paddle overlap uses the pre-step ballY:
  - Left paddle overlaps when ballY+BALL_SIZE > padLeftY and ballY < padLeftY+PAD_H.
  - Right paddle uses the same test with padRightY.
- Horizontal step, moving left:
  - Hit: ballX >= PAD_L_X+PAD_W, ballX < PAD_L_X+PAD_W+SPEED, and left overlap. Set ballX = PAD_L_X+PAD_W, dirX = right.
  - Miss: otherwise if ballX < SPEED. Set ballX = 0, go to SCORED, pulse scoreRight, and set dirX = left (the next serve goes toward the loser).
  - Otherwise ballX -= SPEED.
- Horizontal step, moving right:
  - Hit: ballX+BALL_SIZE <= PAD_R_X, ballX+BALL_SIZE+SPEED > PAD_R_X, and right overlap. Set ballX = PAD_R_X-BALL_SIZE, dirX = left.
  - Miss: otherwise if ballX+BALL_SIZE+SPEED > SCREEN_W. Set ballX = SCREEN_W-BALL_SIZE, go to SCORED, pulse scoreLeft, and set dirX = right.
  - Otherwise ballX += SPEED.
- A ball already past a paddle face cannot bounce off that paddle; it continues to the edge.
- Vertical and horizontal updates happen in the same step. A corner case (wall and paddle in the same frame) applies both.
- scoreLeft/scoreRight are high for exactly one cycle, the cycle after the missing step. They are never both high.
- paddle inputs are sampled only on frameTick cycles.

Test Plan:
1. Reset, serve=1 for one cycle, then 60 frameTicks -> ball holds (317,237) with yellow colour; on the 61st tick ballX=319, ballY=239, inPlay=1, ballColour=111.
2. MOVE, ballY=474, dirY=down, one tick -> ballY=475, dirY=up; next tick -> ballY=473.
3. MOVE, dirX=left, ballX=26, ballY=210, padLeftY=200, tick -> ballX=25, dirX=right; next tick -> ballX=27.
4. Same as 3 but padLeftY=0, ballY=300 -> x becomes 24, 22, … 0 over ticks 1–13. Tick 14 -> SCORED with scoreRight high exactly one cycle. Next tick -> ball at (317,237) in IDLE, dirX=left.
5. MOVE, dirX=right, ballX=609, padRightY=ballY -> ballX=610, dirX=left. With padRightY far away instead, ballX reaches 635 and then scoreLeft pulses.
6. Assert reset in MOVE on the same cycle as frameTick -> reset values next cycle, no score pulse. In IDLE, serve and frameTick in the same cycle -> SERVE_WAIT with counter still 0.
